// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch front end.
package if_pkg;
  localparam int IM_AW_DEFAULT = 11;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;
endpackage

// File: rtl/if_fifo2.sv
// if_fifo2: 2-entry synchronous FIFO of fetch entries with flush; head reads 0 after reset.
module if_fifo2
  import if_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t mem [2];
  logic rd;
  logic wr;
  assign wr   = rd ^ count[0];
  assign head = mem[rd];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd     <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (push) mem[wr] <= din;
      if (pop) rd <= ~rd;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC sequencing, ROM issue and redirect handling feeding a 2-entry output buffer.
// Define IF_FETCH_ALIGN_CHK_EN to add out_fault and trap misaligned redirect targets.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          IM_AW    = IM_AW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             im_ena,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr
`ifdef IF_FETCH_ALIGN_CHK_EN
  , output logic           out_fault
`endif
);
  logic [31:0]  pc, ipc, issue_pc;
  logic         inflight, ifault, halt;
  logic         pop, push, issue, bad;
  logic [1:0]   count;
  fetch_entry_t head, din;
`ifdef IF_FETCH_ALIGN_CHK_EN
  assign bad       = redirect_pc[1:0] != 2'b00;
  assign out_fault = head.fault;
`else
  assign bad = 1'b0;
  wire unused_fault = head.fault;
`endif
  // A redirect kills both the same-cycle pop and the returning read
  assign pop       = out_valid & out_ready & ~redirect_valid;
  assign push      = inflight & ~redirect_valid;
  assign issue_pc  = redirect_valid ? {redirect_pc[31:2], 2'b00} : pc;
  assign issue     = rst_n & (redirect_valid ? ~bad
                   : ~halt & (({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2));
  assign im_ena    = issue;
  assign im_addr   = issue_pc[IM_AW+1:2];
  assign din       = '{pc: ipc, instr: ifault ? INSTR_NOP : im_rdata, fault: ifault};
  assign out_valid = rst_n & (count != 2'd0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  if_fifo2 u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .din  (din),
    .head (head),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= PC_RESET;
      ipc      <= 32'h0;
      inflight <= 1'b0;
      ifault   <= 1'b0;
      halt     <= 1'b0;
    end else begin
      inflight <= issue | (redirect_valid & bad);
      ifault   <= redirect_valid & bad;
      if (redirect_valid) halt <= bad;
      if (issue) begin
        pc  <= issue_pc + 32'd4;
        ipc <= issue_pc;
      end else if (redirect_valid) begin
        ipc <= redirect_pc;
      end
    end
  end
endmodule
